// File: rtl/abs_diff_err_sweep_ctrl.sv
// abs_diff_err_sweep_ctrl: exhaustive error sweep of an approximate abs_diff core.
// Define ABS_DIFF_SWEEP_EARLY_ABORT_EN to end the sweep on the first fold with err > ET.
module abs_diff_err_sweep_ctrl #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3,
   parameter int ET    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_OUT-1:0] max_err,
   output logic [N_IN:0]    err_count,
   output logic [N_IN-1:0]  core_in,
   input  logic [N_OUT-1:0] core_out
);
   localparam int H = N_IN / 2;
   localparam logic [31:0] ET_U = ET;
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
   state_t state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d, p_vec_q, p_vec_d;
   logic [N_OUT-1:0] p_out_q, p_out_d, max_err_q, max_err_d;
   logic [N_IN:0] err_count_q, err_count_d;
   logic p_vld_q, p_vld_d, pass_q, pass_d;
   logic [H-1:0] a, b, diff;
   logic [N_OUT-1:0] exact, err;
   logic abort, pass_now;
   always_comb begin
      a = p_vec_q[H-1:0];
      b = p_vec_q[N_IN-1:H];
      diff = a > b ? a - b : b - a;
      exact = N_OUT'(diff);
      // Both terms are below 2^N_OUT, so the N_OUT-bit difference never wraps.
      err = p_out_q >= exact ? p_out_q - exact : exact - p_out_q;
      pass_now = 32'(max_err_q) <= ET_U;
`ifdef ABS_DIFF_SWEEP_EARLY_ABORT_EN
      abort = p_vld_q && (32'(err) > ET_U);
`else
      abort = 1'b0;
`endif
   end
   always_comb begin
      state_d = state_q;
      vec_d = vec_q;
      p_vec_d = p_vec_q;
      p_out_d = p_out_q;
      p_vld_d = p_vld_q;
      pass_d = pass_q;
      max_err_d = p_vld_q && err > max_err_q ? err : max_err_q;
      err_count_d = p_vld_q ? err_count_q + (N_IN+1)'(err != '0) : err_count_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = SWEEP;
            vec_d = '0;
            max_err_d = '0;
            err_count_d = '0;
            pass_d = 1'b0;
         end
         SWEEP: begin
            p_vec_d = vec_q;
            p_out_d = core_out;
            p_vld_d = 1'b1;
            vec_d = vec_q + N_IN'(1);
            state_d = vec_q == '1 ? DRAIN : SWEEP;
         end
         DRAIN: begin
            p_vld_d = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            pass_d = pass_now;
            state_d = IDLE;
         end
      endcase
      if (abort) begin
         state_d = DONE;
         p_vld_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q <= '0;
         p_vec_q <= '0;
         p_out_q <= '0;
         p_vld_q <= 1'b0;
         max_err_q <= '0;
         err_count_q <= '0;
         pass_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q <= vec_d;
         p_vec_q <= p_vec_d;
         p_out_q <= p_out_d;
         p_vld_q <= p_vld_d;
         max_err_q <= max_err_d;
         err_count_q <= err_count_d;
         pass_q <= pass_d;
      end
   end
   assign busy = state_q == SWEEP || state_q == DRAIN;
   assign done = state_q == DONE;
   assign pass = done ? pass_now : pass_q;
   assign max_err = max_err_q;
   assign err_count = err_count_q;
   assign core_in = vec_q;
endmodule

// File: tb/tb_abs_diff_err_sweep_ctrl.sv
// tb_abs_diff_err_sweep_ctrl: directed sweeps against exact and constant cores.
module tb_abs_diff_err_sweep_ctrl;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic busy, done, pass;
   logic [2:0] max_err, core_out;
   logic [4:0] err_count;
   logic [3:0] core_in;
   logic [1:0] mode = 2'd0, ta, tb_b;
   int cyc = 0, checks = 0, errors = 0, t0 = 0, lat;

   abs_diff_err_sweep_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
      .max_err(max_err), .err_count(err_count), .core_in(core_in), .core_out(core_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign ta = core_in[1:0];
   assign tb_b = core_in[3:2];
   assign core_out = mode == 2'd0 ? {1'b0, (ta > tb_b ? ta - tb_b : tb_b - ta)} :
                     mode == 2'd1 ? 3'b001 : 3'b111;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic accept();
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 t0 = cyc;
      @(negedge clk) start = 1'b0;
      chk("first_busy", busy, 1);
      chk("first_core_in", core_in, 0);
      chk("cleared_pass", pass, 0);
      chk("cleared_max", max_err, 0);
      chk("cleared_cnt", err_count, 0);
   endtask

   task automatic wait_done(input bit pulse, output int l);
      bit got = 0;
      l = -1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         start = pulse && (cyc - t0 == 4 || cyc - t0 == 16);
         if (cyc - t0 == 5) chk("core_in_v5", core_in, 5);
         if (done) begin
            got = 1;
            l = cyc - t0;
         end
      end
      start = 1'b0;
      chk("done_seen", got, 1);
   endtask

   task automatic run(input logic [1:0] m, input bit pulse, input int e_lat,
                      input int e_max, input int e_cnt, input int e_pass);
      mode = m;
      accept();
      wait_done(pulse, lat);
      chk("done_latency", lat, e_lat);
      chk("max_err", max_err, e_max);
      chk("err_count", err_count, e_cnt);
      chk("pass", pass, e_pass);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("hold_pass", pass, e_pass);
      chk("hold_max", max_err, e_max);
      chk("hold_cnt", err_count, e_cnt);
      repeat (3) @(negedge clk);
      chk("no_second_done", done, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_max", max_err, 0);
      chk("rst_cnt", err_count, 0);
      chk("rst_core_in", core_in, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_start", busy, 0);
      run(2'd0, 1'b0, 17, 0, 0, 1);
      run(2'd1, 1'b0, 17, 2, 10, 1);
`ifdef ABS_DIFF_SWEEP_EARLY_ABORT_EN
      run(2'd2, 1'b0, 2, 7, 1, 0);
`else
      run(2'd2, 1'b0, 17, 7, 16, 0);
`endif
      run(2'd1, 1'b1, 17, 2, 10, 1);
      mode = 2'd1;
      accept();
      repeat (8) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_pass", pass, 0);
      chk("mid_rst_max", max_err, 0);
      chk("mid_rst_cnt", err_count, 0);
      chk("mid_rst_core_in", core_in, 0);
      @(negedge clk);
      accept();
      wait_done(1'b0, lat);
      chk("rerun_latency", lat, 17);
      chk("rerun_max", max_err, 2);
      chk("rerun_cnt", err_count, 10);
      chk("rerun_pass", pass, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
